spi_byte_decoder: RTL
=====================

# spi_byte_decoder

Command decoder between the SPI byte receiver and the pixel RAM. It consumes the one-cycle byte strobe and byte produced by the SPI receiver in the `clk_in` domain. It parses each chip-select transaction as a command byte followed by arguments or pixel data, and drives the RAM write port with an auto-incrementing address. It emits a refresh pulse that tells the LED output stage to start streaming a frame.

## Interface
- `ADDR_W`, 10: RAM address width; RAM depth is 2^ADDR_W bytes.
- `CMD_ADDR`, 8'h2A: command byte for set-address.
- `CMD_WRITE`, 8'h2C: command byte for write-memory.
- `CMD_REFRESH`, 8'h3C: command byte for request-refresh.

Ports:
- `clk_in`  in  1: system clock (200 MHz).
- `rst_in`  in  1: **one clock; reset is synchronous and active-high.**
- `spi_cs_n_in`  in  1: raw SPI chip select, asynchronous to `clk_in`.
- `byte_valid_in`  in  1: one-cycle strobe; `byte_data_in` is valid.
- `byte_data_in`  in  8: received byte.
- `ram_wr_en_out`  out  1: RAM write enable, one cycle per byte.
- `ram_wr_addr_out`  out  ADDR_W: RAM write address.
- `ram_wr_data_out`  out  8: RAM write data.
- `refresh_out`  out  1: one-cycle refresh request.
- `frame_cnt_out`  out  16: count of refresh commands (see Configuration).

## Operation
- `spi_cs_n_in` passes through a 2-FF synchronizer plus an edge register. A synchronized falling edge marks the start of a transaction and forces state IDLE from any state. Any byte-phase counters are cleared at the same time.
- States and transitions on `byte_valid_in`:
  - IDLE: byte equals CMD_ADDR → ADDR_HI.
  - IDLE: byte equals CMD_WRITE → WRITE.
  - IDLE: byte equals CMD_REFRESH → pulse `refresh_out`, then DISCARD.
  - IDLE: any other byte → DISCARD.
  - ADDR_HI: latch byte into address[15:8] staging → ADDR_LO.
  - ADDR_LO: write pointer ← {hi,lo}[ADDR_W-1:0], with upper bits truncated → DISCARD.
  - WRITE: write the byte at the pointer, pointer += 1 → stay in WRITE.
  - DISCARD: ignore all bytes until the next transaction start.
- The pointer wraps from 2^ADDR_W−1 to 0 silently.
- The pointer persists across transactions. Only CMD_ADDR or reset changes it, apart from increments during writes.
- If the transaction-start edge and `byte_valid_in` fall in the same cycle, the start edge wins: the state goes to IDLE and the byte is dropped.

## Timing
- Reset values:
  - state IDLE, pointer 0.
  - `ram_wr_en_out` 0, `ram_wr_addr_out` 0, `ram_wr_data_out` 0.
  - `refresh_out` 0, `frame_cnt_out` 0.
  - Synchronizer flops reset to 1 (CS idle).
- Write latency: `ram_wr_en_out`, `ram_wr_addr_out` and `ram_wr_data_out` are registered and asserted 1 cycle after `byte_valid_in`.
  - The address presented is the pointer value before the increment.
  - Address and data hold their values when `ram_wr_en_out` is 0.
- `refresh_out` is asserted 1 cycle after the CMD_REFRESH strobe, for exactly 1 cycle.
- Start-of-transaction detection latency: 3 `clk_in` cycles from the `spi_cs_n_in` falling edge.
- Back-to-back strobes on consecutive cycles must be accepted; no byte is lost.
- Reset asserted mid-transaction: the state returns to IDLE. Subsequent bytes go to DISCARD until the next transaction-start edge, because the cleared synchronizer does not produce a spurious edge.

## Configuration
- `SPI_DECODER_FRAME_CNT_EN` defined:
  - `frame_cnt_out` is a 16-bit counter incremented in the same cycle `refresh_out` asserts.
  - It wraps from 16'hFFFF to 0 and is cleared by reset.
- Not defined: `frame_cnt_out` is tied to 16'h0000 and no counter logic is synthesized.

## Test plan
- Reset, then transaction 2A 01 05 → pointer = 10'h105 and no `ram_wr_en_out`. Follow with transaction 2C AA BB → writes AA@0x105 and BB@0x106, each 1 cycle after its strobe.
- Transaction 2A 03 FE, then transaction 2C 11 22 33 → writes 11@0x3FE, 22@0x3FF, 33@0x000 (wrap).
- Transaction 3C → `refresh_out` is high exactly 1 cycle. With `SPI_DECODER_FRAME_CNT_EN`, three such transactions → `frame_cnt_out` = 3; without the macro it stays 0.
- Transaction 55 2C 77 → no writes, no refresh. The next transaction 2C 77 → one write of 77 at the current pointer.
- Strobes on consecutive cycles in WRITE with data 01,02,03,04 → four consecutive write cycles with addresses incrementing by 1.
- Assert `rst_in` mid-WRITE after 2 bytes, continue strobing → no further writes until a new CS falling edge. Then 2C 09 → write 09@0x000.

Source files
------------

// File: rtl/spi_byte_decoder_if.sv
// Byte-stream input and RAM write / refresh outputs of spi_byte_decoder.
// The decoder connects through the slave modport; the byte source and RAM side use master.
interface spi_byte_decoder_if #(
    parameter int ADDR_W = 10
);
    logic              byte_valid_in;
    logic [7:0]        byte_data_in;
    logic              ram_wr_en_out;
    logic [ADDR_W-1:0] ram_wr_addr_out;
    logic [7:0]        ram_wr_data_out;
    logic              refresh_out;
    logic [15:0]       frame_cnt_out;

    modport slave (
        input  byte_valid_in,
        input  byte_data_in,
        output ram_wr_en_out,
        output ram_wr_addr_out,
        output ram_wr_data_out,
        output refresh_out,
        output frame_cnt_out
    );

    modport master (
        output byte_valid_in,
        output byte_data_in,
        input  ram_wr_en_out,
        input  ram_wr_addr_out,
        input  ram_wr_data_out,
        input  refresh_out,
        input  frame_cnt_out
    );
endinterface

// File: rtl/spi_byte_decoder.sv
// SPI command decoder: parses set-address / write-memory / refresh commands into RAM writes.
// Define SPI_DECODER_FRAME_CNT_EN to build the 16-bit refresh (frame) counter.
module spi_byte_decoder #(
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] CMD_ADDR    = 8'h2A,
    parameter logic [7:0] CMD_WRITE   = 8'h2C,
    parameter logic [7:0] CMD_REFRESH = 8'h3C
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             spi_cs_n_in,
    spi_byte_decoder_if.slave bus
);

    // High-byte staging keeps only the bits that survive truncation (ADDR_W in 9..16).
    localparam int HI_W = ADDR_W - 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR_HI = 3'd1;
    localparam logic [2:0] ST_ADDR_LO = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    logic [2:0]        state;
    logic [HI_W-1:0]   addr_hi;
    logic [ADDR_W-1:0] ptr;

    logic              cs_meta;
    logic              cs_sync;
    logic              cs_prev;
    logic [1:0]        sync_fill;
    logic              armed;
    logic              txn_start;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              refresh;
    logic              refresh_hit;

    // A falling edge only counts once CS has been seen idle since reset, so a
    // reset in the middle of a transaction cannot fake a start edge.
    assign txn_start   = armed & cs_prev & ~cs_sync;
    assign refresh_hit = bus.byte_valid_in & ~txn_start & (state == ST_IDLE)
                         & (bus.byte_data_in == CMD_REFRESH);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: synchronizer flops reset to the idle (high) CS level, not 0,
            // otherwise the release of reset itself would look like a CS edge.
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
            state     <= ST_IDLE;
            addr_hi   <= '0;
            ptr       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            refresh   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop samples
            // the pre-edge value of the others regardless of statement order.
            cs_meta   <= spi_cs_n_in;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & cs_sync);

            wr_en     <= 1'b0;
            refresh   <= refresh_hit;

            if (txn_start) begin
                state <= ST_IDLE;
            end else if (bus.byte_valid_in) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.byte_data_in == CMD_ADDR)       state <= ST_ADDR_HI;
                        else if (bus.byte_data_in == CMD_WRITE) state <= ST_WRITE;
                        else                                    state <= ST_DISCARD;
                    end
                    ST_ADDR_HI: begin
                        addr_hi <= bus.byte_data_in[HI_W-1:0];
                        state   <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        ptr   <= {addr_hi, bus.byte_data_in};
                        state <= ST_DISCARD;
                    end
                    ST_WRITE: begin
                        wr_en   <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= bus.byte_data_in;
                        ptr     <= ptr + ADDR_W'(1);
                    end
                    default: state <= ST_DISCARD;
                endcase
            end
        end
    end

    assign bus.ram_wr_en_out   = wr_en;
    assign bus.ram_wr_addr_out = wr_addr;
    assign bus.ram_wr_data_out = wr_data;
    assign bus.refresh_out     = refresh;

`ifdef SPI_DECODER_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    // Counts on the same edge that raises refresh_out, so the new count appears with the pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in)           frame_cnt <= 16'h0000;
        else if (refresh_hit) frame_cnt <= frame_cnt + 16'd1;
    end

    assign bus.frame_cnt_out = frame_cnt;
`else
    assign bus.frame_cnt_out = 16'h0000;
`endif

endmodule
